// File: rtl/arith_pkg.sv
// Shared arithmetic definitions: serial-subtractor state encoding, default width
// and the bit-counter width helper.
package arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sub_state_t;

    localparam int SUB_DEFAULT_W = 8;

    // Counter must hold the values 0..W, hence W+1 distinct codes.
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor, gate level: d = a - b - b_in, b_out = borrow out.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic b_in,
    output logic d,
    output logic b_out
);

    logic ab_x;
    logic gen_b;
    logic prop_b;

    assign ab_x   = a ^ b;
    assign d      = ab_x ^ b_in;
    assign gen_b  = ~a & b;
    assign prop_b = ~ab_x & b_in;
    assign b_out  = gen_b | prop_b;

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial W-bit subtractor (diff = a - b, LSB first) with start/busy/done handshake.
// Optional signed-overflow output enabled by defining SUB_SIGNED_OVF_EN.
module serial_subtractor
    import arith_pkg::*;
#(
    parameter int W = SUB_DEFAULT_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] diff,
`ifdef SUB_SIGNED_OVF_EN
    output logic         ovf,
`endif
    output logic         borrow_out
);

    localparam int CNT_W = cnt_width(W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(W - 1);

    sub_state_t       state_q, state_d;
    logic [W-1:0]     a_sh_q, a_sh_d;
    logic [W-1:0]     b_sh_q, b_sh_d;
    logic [W-1:0]     res_sh_q, res_sh_d;
    logic             borrow_q, borrow_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [W-1:0]     diff_q, diff_d;
    logic             borrow_out_q, borrow_out_d;

    logic             bit_d;
    logic             bit_b;

`ifdef SUB_SIGNED_OVF_EN
    logic             a_sign_q, a_sign_d;
    logic             b_sign_q, b_sign_d;
    logic             ovf_q, ovf_d;
`endif

    full_subtractor u_fs (
        .a     (a_sh_q[0]),
        .b     (b_sh_q[0]),
        .b_in  (borrow_q),
        .d     (bit_d),
        .b_out (bit_b)
    );

    always_comb begin
        state_d      = state_q;
        a_sh_d       = a_sh_q;
        b_sh_d       = b_sh_q;
        res_sh_d     = res_sh_q;
        borrow_d     = borrow_q;
        cnt_d        = cnt_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        diff_d       = diff_q;
        borrow_out_d = borrow_out_q;
`ifdef SUB_SIGNED_OVF_EN
        a_sign_d     = a_sign_q;
        b_sign_d     = b_sign_q;
        ovf_d        = ovf_q;
`endif

        case (state_q)
            // DONE accepts a new start exactly like IDLE, enabling back-to-back runs.
            IDLE, DONE: begin
                busy_d  = start;
                state_d = IDLE;
                if (start) begin
                    a_sh_d   = a;
                    b_sh_d   = b;
                    res_sh_d = '0;
                    borrow_d = 1'b0;
                    cnt_d    = '0;
                    state_d  = RUN;
`ifdef SUB_SIGNED_OVF_EN
                    a_sign_d = a[W-1];
                    b_sign_d = b[W-1];
`endif
                end
            end
            RUN: begin
                res_sh_d = {bit_d, res_sh_q[W-1:1]};
                a_sh_d   = {1'b0, a_sh_q[W-1:1]};
                b_sh_d   = {1'b0, b_sh_q[W-1:1]};
                borrow_d = bit_b;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == LAST_BIT) begin
                    state_d      = DONE;
                    busy_d       = 1'b0;
                    done_d       = 1'b1;
                    diff_d       = {bit_d, res_sh_q[W-1:1]};
                    borrow_out_d = bit_b;
`ifdef SUB_SIGNED_OVF_EN
                    // Operand signs differ and the result sign differs from the minuend.
                    ovf_d        = (a_sign_q ^ b_sign_q) & (a_sign_q ^ bit_d);
`endif
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            a_sh_q       <= '0;
            b_sh_q       <= '0;
            res_sh_q     <= '0;
            borrow_q     <= 1'b0;
            cnt_q        <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            diff_q       <= '0;
            borrow_out_q <= 1'b0;
`ifdef SUB_SIGNED_OVF_EN
            a_sign_q     <= 1'b0;
            b_sign_q     <= 1'b0;
            ovf_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            a_sh_q       <= a_sh_d;
            b_sh_q       <= b_sh_d;
            res_sh_q     <= res_sh_d;
            borrow_q     <= borrow_d;
            cnt_q        <= cnt_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            diff_q       <= diff_d;
            borrow_out_q <= borrow_out_d;
`ifdef SUB_SIGNED_OVF_EN
            a_sign_q     <= a_sign_d;
            b_sign_q     <= b_sign_d;
            ovf_q        <= ovf_d;
`endif
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign diff       = diff_q;
    assign borrow_out = borrow_out_q;
`ifdef SUB_SIGNED_OVF_EN
    assign ovf        = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor (W=8); ovf checks are
// included when SUB_SIGNED_OVF_EN is defined.
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         borrow_out;
`ifdef SUB_SIGNED_OVF_EN
    logic         ovf;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    serial_subtractor #(.W(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .diff       (diff),
`ifdef SUB_SIGNED_OVF_EN
        .ovf        (ovf),
`endif
        .borrow_out (borrow_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Wait for done; returns the number of edges waited and busy-high samples seen.
    task automatic wait_done(output int lat, inout int busy_n);
        lat = 0;
        while (!done && lat < 20) begin
            @(posedge clk); #1;
            lat++;
            if (busy) busy_n++;
        end
        check("done_seen", {31'b0, done}, 32'd1);
    endtask

    task automatic check_result(input string tag, input logic [W-1:0] exp_d,
                                input logic exp_b, input logic exp_o);
        check({tag, "_diff"}, {24'b0, diff}, {24'b0, exp_d});
        check({tag, "_borrow"}, {31'b0, borrow_out}, {31'b0, exp_b});
`ifdef SUB_SIGNED_OVF_EN
        check({tag, "_ovf"}, {31'b0, ovf}, {31'b0, exp_o});
`else
        if (exp_o !== exp_o) $display("unused");
`endif
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic [W-1:0] exp_d, input logic exp_b, input logic exp_o);
        int lat;
        int busy_n;
        @(negedge clk);
        start = 1'b1; a = av; b = bv;
        @(posedge clk); #1;
        start = 1'b0; a = ~av; b = ~bv;
        busy_n = busy ? 1 : 0;
        wait_done(lat, busy_n);
        check({tag, "_latency"}, lat, 32'd8);
        check({tag, "_busy_cycles"}, busy_n, 32'd8);
        check_result(tag, exp_d, exp_b, exp_o);
        @(posedge clk); #1;
        check({tag, "_done_single"}, {31'b0, done}, 32'd0);
        check({tag, "_diff_hold"}, {24'b0, diff}, {24'b0, exp_d});
    endtask

    initial begin
        int lat;
        int busy_n;
        int extra_done;

        #1;
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_diff", {24'b0, diff}, 32'd0);
        check("rst_borrow", {31'b0, borrow_out}, 32'd0);
`ifdef SUB_SIGNED_OVF_EN
        check("rst_ovf", {31'b0, ovf}, 32'd0);
`endif
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run_op("basic", 8'h05, 8'h03, 8'h02, 1'b0, 1'b0);
        run_op("neg",   8'h03, 8'h05, 8'hFE, 1'b1, 1'b0);
        run_op("zero",  8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        run_op("ovf1",  8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);
        run_op("ovf2",  8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1);

        // Start during busy is ignored.
        @(negedge clk);
        start = 1'b1; a = 8'h10; b = 8'h01;
        @(posedge clk); #1;
        start = 1'b0;
        busy_n = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        start = 1'b1; a = 8'hAA; b = 8'h11;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(lat, busy_n);
        check("ign_latency", lat, 32'd5);
        check_result("ign", 8'h0F, 1'b0, 1'b0);
        extra_done = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (done) extra_done++;
        end
        check("ign_extra_done", extra_done, 32'd0);
        check("ign_busy_after", {31'b0, busy}, 32'd0);

        // Asynchronous reset mid-operation.
        @(negedge clk);
        start = 1'b1; a = 8'h55; b = 8'h11;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_busy", {31'b0, busy}, 32'd0);
        check("arst_done", {31'b0, done}, 32'd0);
        check("arst_diff", {24'b0, diff}, 32'd0);
        check("arst_borrow", {31'b0, borrow_out}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run_op("post_rst", 8'hFF, 8'h01, 8'hFE, 1'b0, 1'b0);

        // Back-to-back: start held through DONE.
        @(negedge clk);
        start = 1'b1; a = 8'h20; b = 8'h30;
        @(posedge clk); #1;
        a = 8'h09; b = 8'h04;
        busy_n = 1;
        wait_done(lat, busy_n);
        check("b2b1_latency", lat, 32'd8);
        check_result("b2b1", 8'hF0, 1'b1, 1'b0);
        @(posedge clk); #1;
        start = 1'b0;
        check("b2b_done_drop", {31'b0, done}, 32'd0);
        check("b2b_busy_again", {31'b0, busy}, 32'd1);
        wait_done(lat, busy_n);
        check("b2b_gap", lat + 1, 32'd9);
        check_result("b2b2", 8'h05, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
